// File: rtl/instr_sequencer.sv
// ALU opcode package and the fetch/decode/exec/mem control sequencer
// that feeds the combinational ALU from a synchronous instruction ROM.
package definitions;
  typedef enum logic [4:0] {
    oLSR    = 5'd0,
    oRSR    = 5'd1,
    oMOVER  = 5'd2,
    oMOVEA  = 5'd3,
    oXOR    = 5'd4,
    oRXOR   = 5'd5,
    oAND    = 5'd6,
    oANDI   = 5'd7,
    oADD    = 5'd8,
    oADDI   = 5'd9,
    oSUB    = 5'd10,
    oLUT    = 5'd11,
    oBEQ    = 5'd12,
    oBNE    = 5'd13,
    oBLE    = 5'd14,
    oBLT    = 5'd15,
    oJUMP   = 5'd16,
    oLOAD   = 5'd17,
    oSTORE  = 5'd18
  } op_mne;
endpackage

module instr_sequencer
  import definitions::*;
#(
  parameter int          PC_W      = 10,
  parameter logic [12:0] HALT_WORD = 13'h1FFF
) (
  input  logic            CLK,
  input  logic            Reset_n,
  input  logic            Start,
  output logic            Done,
  output logic [PC_W-1:0] InstAddr,
  input  logic [12:0]     InstIn,
  output logic [4:0]      OP,
  output logic [4:0]      Imm,
  input  logic            Zero,
  output logic [2:0]      RaAddr,
  output logic [2:0]      RbAddr,
  output logic            RegWrEn,
  output logic            WbSel,
  output logic            MemReq,
  output logic            MemWe,
  input  logic            MemAck
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [12:0]       ir_q, ir_d;

  logic [4:0]        opc;
  logic              is_wr;
  logic              is_br;
  logic              is_jmp;
  logic              is_mem;
  logic              is_st;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   pc_off;

  assign opc    = ir_q[12:8];
  assign is_wr  = opc inside {oLSR, oRSR, oMOVER, oMOVEA,
                              oXOR, oRXOR, oAND, oANDI,
                              oADD, oADDI, oSUB, oLUT};
  assign is_br  = opc inside {oBEQ, oBNE, oBLE, oBLT};
  assign is_jmp = (opc == oJUMP);
  assign is_st  = (opc == oSTORE);
  assign is_mem = (opc == oLOAD) || is_st;

  // Wraps modulo 2^PC_W naturally through the truncating add.
  assign pc_inc = pc_q + PC_W'(1);
  assign pc_off = pc_q + {{(PC_W-5){ir_q[4]}}, ir_q[4:0]};

  assign InstAddr = pc_q;
  assign OP       = opc;
  assign Imm      = ir_q[4:0];
  assign RaAddr   = ir_q[7:5];
  assign RbAddr   = ir_q[2:0];

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    RegWrEn = 1'b0;
    WbSel   = 1'b0;
    MemReq  = 1'b0;
    MemWe   = 1'b0;
    Done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ir_d    = InstIn;
        state_d = (InstIn == HALT_WORD) ? S_HALT
                                        : S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        unique case (1'b1)
          is_wr: begin
            RegWrEn = 1'b1;
          end
          is_br: begin
            // ALU drives Out=1 on a true condition, so Zero=0 means taken.
            if (!Zero) pc_d = pc_off;
          end
          is_jmp: begin
            pc_d = pc_off;
          end
          is_mem: begin
            MemReq  = 1'b1;
            MemWe   = is_st;
            pc_d    = pc_q;
            state_d = S_MEM;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        MemReq = 1'b1;
        MemWe  = is_st;
        if (MemAck) begin
          RegWrEn = !is_st;
          WbSel   = !is_st;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        Done = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed scenarios plus a random program
// run against an instruction-level interpreter of the sequencer.
module tb_instr_sequencer;
  import definitions::*;

  localparam int          PC_W = 10;
  localparam int          NPC  = 1 << PC_W;
  localparam logic [12:0] HW   = 13'h1FFF;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            done;
  logic [PC_W-1:0] inst_addr;
  logic [12:0]     inst_in = '0;
  logic [4:0]      op;
  logic [4:0]      imm;
  logic            zero = 1'b0;
  logic [2:0]      ra;
  logic [2:0]      rb;
  logic            reg_wr;
  logic            wb_sel;
  logic            mem_req;
  logic            mem_we;
  logic            mem_ack = 1'b0;

  logic [12:0] rom [0:NPC-1];

  int n_chk = 0;
  int n_fail = 0;

  instr_sequencer #(.PC_W(PC_W), .HALT_WORD(HW)) dut (
    .CLK(clk), .Reset_n(rst_n), .Start(start), .Done(done),
    .InstAddr(inst_addr), .InstIn(inst_in), .OP(op), .Imm(imm),
    .Zero(zero), .RaAddr(ra), .RbAddr(rb), .RegWrEn(reg_wr),
    .WbSel(wb_sel), .MemReq(mem_req), .MemWe(mem_we),
    .MemAck(mem_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) inst_in <= rom[inst_addr];

  function automatic logic [12:0] mk(input op_mne o,
                                     input int r, input int i);
    return {o, 3'(r), 5'(i)};
  endfunction

  function automatic bit m_write(input logic [4:0] o);
    return o inside {oLSR, oRSR, oMOVER, oMOVEA, oXOR, oRXOR,
                     oAND, oANDI, oADD, oADDI, oSUB, oLUT};
  endfunction

  function automatic bit m_branch(input logic [4:0] o);
    return o inside {oBEQ, oBNE, oBLE, oBLT};
  endfunction

  function automatic int m_rel(input int pc, input logic [4:0] i);
    int off;
    off = (i >= 5'd16) ? int'(i) - 32 : int'(i);
    return (pc + off + NPC) % NPC;
  endfunction

  task automatic cyc(input logic s, input logic z, input logic a);
    @(posedge clk);
    #1;
    start = s;
    zero = z;
    mem_ack = a;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    start = 1'b0;
    zero = 1'b0;
    mem_ack = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NPC; i++) rom[i] = mk(oADD, 0, 0);
    #2;
    n_chk++;
    if ({done, reg_wr, wb_sel, mem_req, mem_we} !== 5'b0 ||
        op !== 5'd0 || imm !== 5'd0 || inst_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got d%b w%b s%b r%b e%b op%h imm%h pc%h want all 0",
               done, reg_wr, wb_sel, mem_req, mem_we, op, imm, inst_addr);
    end
    do_reset();
    for (int c = 0; c < 3; c++) begin
      cyc(1'b0, 1'b1, 1'b1);
      n_chk++;
      if (reg_wr !== 1'b0 || mem_req !== 1'b0 || done !== 1'b0 ||
          inst_addr !== '0) begin
        n_fail++;
        $display("FAIL idle_quiet: got w%b r%b d%b pc%0d want 0 0 0 0",
                 reg_wr, mem_req, done, inst_addr);
      end
    end
  endtask

  task automatic test_addi_halt();
    rom[0] = mk(oADDI, 1, 3);
    rom[1] = HW;
    do_reset();
    cyc(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      cyc(1'b0, 1'b0, 1'b0);
      n_chk++;
      if (reg_wr !== (c == 3)) begin
        n_fail++;
        $display("FAIL addi_regwr c%0d: got %b want %b", c, reg_wr, c == 3);
      end
      if (c == 3) begin
        n_chk++;
        if (ra !== 3'd1 || imm !== 5'd3 || op !== oADDI || wb_sel !== 1'b0) begin
          n_fail++;
          $display("FAIL addi_fields: got ra%0d imm%0d op%0d wb%b want 1 3 %0d 0",
                   ra, imm, op, wb_sel, oADDI);
        end
      end
      if (c <= 4 || c >= 6) begin
        n_chk++;
        if (done !== (c >= 6)) begin
          n_fail++;
          $display("FAIL halt_done c%0d: got %b want %b", c, done, c >= 6);
        end
      end
      if (c >= 6) begin
        n_chk++;
        if (inst_addr !== 10'd1) begin
          n_fail++;
          $display("FAIL halt_pc c%0d: got %0d want 1", c, inst_addr);
        end
      end
    end
  endtask

  task automatic test_branch();
    for (int z = 0; z < 2; z++) begin
      rom[0] = mk(oJUMP, 0, 5);
      rom[5] = mk(oBEQ, 4, 5'b11110);
      do_reset();
      cyc(1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 7; c++) begin
        cyc(1'b0, z[0], 1'b0);
        if (c == 6) begin
          n_chk++;
          if (reg_wr !== 1'b0 || op !== oBEQ) begin
            n_fail++;
            $display("FAIL beq_exec: got w%b op%0d want 0 %0d",
                     reg_wr, op, oBEQ);
          end
        end
      end
      n_chk++;
      if (inst_addr !== ((z == 0) ? 10'd3 : 10'd6)) begin
        n_fail++;
        $display("FAIL beq_target z%0d: got %0d want %0d",
                 z, inst_addr, (z == 0) ? 3 : 6);
      end
    end
  endtask

  task automatic test_load();
    int req_n;
    req_n = 0;
    rom[0] = mk(oLOAD, 2, 5);
    rom[1] = HW;
    do_reset();
    cyc(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      cyc(1'b0, 1'b0, (c == 3) || (c == 5));
      if (mem_req === 1'b1) req_n++;
      if (c >= 3 && c <= 5) begin
        n_chk++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || ra !== 3'd2 ||
            rb !== 3'd5 || op !== oLOAD) begin
          n_fail++;
          $display("FAIL load_hold c%0d: got r%b we%b ra%0d rb%0d op%0d want 1 0 2 5 %0d",
                   c, mem_req, mem_we, ra, rb, op, oLOAD);
        end
      end
      n_chk++;
      if (reg_wr !== (c == 5) || wb_sel !== (c == 5)) begin
        n_fail++;
        $display("FAIL load_wb c%0d: got w%b s%b want %b",
                 c, reg_wr, wb_sel, c == 5);
      end
    end
    n_chk++;
    if (req_n != 3 || inst_addr !== 10'd1 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL load_done: got req%0d pc%0d r%b want 3 1 0",
               req_n, inst_addr, mem_req);
    end
  endtask

  task automatic test_reset_mem();
    rom[0] = mk(oSTORE, 3, 1);
    do_reset();
    cyc(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 4; c++) cyc(1'b0, 1'b0, 1'b0);
    n_chk++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL store_req: got r%b we%b want 1 1", mem_req, mem_we);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || op !== 5'd0 ||
        imm !== 5'd0 || inst_addr !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got r%b we%b op%0d imm%0d pc%0d want 0",
               mem_req, mem_we, op, imm, inst_addr);
    end
    #2;
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b1);
    n_chk++;
    if (mem_req !== 1'b0 || reg_wr !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got r%b w%b d%b want 0 0 0",
               mem_req, reg_wr, done);
    end
    rom[0] = mk(oADD, 1, 2);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    n_chk++;
    if (reg_wr !== 1'b1 || op !== oADD || ra !== 3'd1) begin
      n_fail++;
      $display("FAIL restart_exec: got w%b op%0d ra%0d want 1 %0d 1",
               reg_wr, op, ra, oADD);
    end
  endtask

  task automatic test_jump_wrap();
    rom[0] = mk(oJUMP, 0, 5'b11111);
    rom[NPC-1] = mk(oJUMP, 0, 1);
    do_reset();
    cyc(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      cyc((c == 3) || (c == 6), 1'b0, 1'b0);
      if (c == 4) begin
        n_chk++;
        if (inst_addr !== 10'(NPC-1)) begin
          n_fail++;
          $display("FAIL jump_back_wrap: got %0d want %0d", inst_addr, NPC-1);
        end
      end
    end
    n_chk++;
    if (inst_addr !== 10'd0) begin
      n_fail++;
      $display("FAIL jump_fwd_wrap: got %0d want 0", inst_addr);
    end
  endtask

  task automatic test_random();
    int mpc, d, n_instr;
    logic [12:0] w;
    logic [4:0] o;
    logic z, mem, st;
    for (int i = 0; i < NPC; i++) begin
      w = 13'($urandom);
      if ($urandom_range(0, 99) < 3) w = HW;
      else if (w == HW) w = mk(oSUB, 0, 0);
      rom[i] = w;
    end
    rom[0] = mk(oADDI, 1, 1);
    do_reset();
    cyc(1'b1, 1'b0, 1'b0);
    mpc = 0;
    n_instr = 0;
    while (n_instr < 160) begin
      n_instr++;
      w = rom[mpc];
      o = w[12:8];
      cyc(1'($urandom), 1'($urandom), 1'($urandom));
      n_chk++;
      if (inst_addr !== 10'(mpc) || reg_wr !== 1'b0 ||
          mem_req !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd_fetch i%0d: got pc%0d w%b r%b d%b want pc%0d 0 0 0",
                 n_instr, inst_addr, reg_wr, mem_req, done, mpc);
      end
      cyc(1'($urandom), 1'($urandom), 1'($urandom));
      if (w == HW) begin
        for (int c = 0; c < 3; c++) begin
          cyc(1'($urandom), 1'($urandom), 1'($urandom));
          n_chk++;
          if (done !== 1'b1 || inst_addr !== 10'(mpc) || reg_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_halt: got d%b pc%0d w%b want 1 %0d 0",
                     done, inst_addr, reg_wr, mpc);
          end
        end
        do_reset();
        cyc(1'b1, 1'b0, 1'b0);
        mpc = 0;
        continue;
      end
      z = 1'($urandom);
      mem = (o == oLOAD) || (o == oSTORE);
      st = (o == oSTORE);
      cyc(1'($urandom), z, 1'($urandom));
      n_chk++;
      if (op !== o || imm !== w[4:0] || ra !== w[7:5] || rb !== w[2:0] ||
          reg_wr !== m_write(o) || wb_sel !== 1'b0 || mem_req !== mem ||
          (mem && mem_we !== st)) begin
        n_fail++;
        $display("FAIL rnd_exec i%0d w%h: got op%0d imm%0d ra%0d rb%0d w%b s%b r%b e%b",
                 n_instr, w, op, imm, ra, rb, reg_wr, wb_sel, mem_req, mem_we);
      end
      if (mem) begin
        d = $urandom_range(0, 3);
        for (int k = 0; k <= d; k++) begin
          cyc(1'($urandom), 1'($urandom), k == d);
          n_chk++;
          if (mem_req !== 1'b1 || mem_we !== st || op !== o ||
              reg_wr !== (k == d && !st) || wb_sel !== (k == d && !st)) begin
            n_fail++;
            $display("FAIL rnd_mem i%0d k%0d: got r%b e%b w%b s%b op%0d",
                     n_instr, k, mem_req, mem_we, reg_wr, wb_sel, op);
          end
        end
        mpc = (mpc + 1) % NPC;
      end else if (o == oJUMP || (m_branch(o) && !z)) begin
        mpc = m_rel(mpc, w[4:0]);
      end else begin
        mpc = (mpc + 1) % NPC;
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi_halt();
    test_branch();
    test_load();
    test_reset_mem();
    test_jump_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
